// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-hierarchy types: word, RAM handshake state and
// bus arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter.sv
// Serialises icache and dcache requests onto one RAM port. Dcache wins
// arbitration unless icache has been passed over STARVE_LIMIT times in a row.
module bus_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] SLIM = CW'(STARVE_LIMIT);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic          d_req_s;
  logic          ram_access_s;

  assign d_req_s      = dREN | dWEN;
  assign ram_access_s = (ramstate_t'(ramstate) == ACCESS);

  // Next state, starvation counter and RAM/cache outputs; outputs depend only
  // on the registered state and the granted requester's inputs.
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = 32'h0000_0000;
    dload    = 32'h0000_0000;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (iREN && (scnt_q == SLIM)) begin
          state_d = IACC;
          scnt_d  = '0;
        end else if (d_req_s) begin
          state_d = DACC;
          if (iREN && (scnt_q != SLIM)) begin
            scnt_d = scnt_q + CW'(1);
          end else begin
            scnt_d = scnt_q;
          end
        end else if (iREN) begin
          state_d = IACC;
          scnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      IACC: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_access_s) begin
            iwait   = 1'b0;
            iload   = ramload;
            state_d = IDLE;
          end else begin
            state_d = IACC;
          end
        end
      end
      DACC: begin
        if (!d_req_s) begin
          state_d = IDLE;
        end else begin
          // A simultaneous read and write request is served as a write.
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ram_access_s) begin
            dwait   = 1'b0;
            dload   = ramload;
            state_d = IDLE;
          end else begin
            state_d = DACC;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and starvation counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter; the bench plays the RAM by driving
// ramstate/ramload cycle by cycle.
module tb_bus_arbiter;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int n_checks = 0;
  int n_pass   = 0;

  bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; iREN = 1'b0; iaddr = 32'h0; dREN = 1'b0; dWEN = 1'b0;
    daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = FREE;
    step; step;
    #1;
    check("rst_iwait",  {31'd0, iwait},  32'd1);
    check("rst_dwait",  {31'd0, dwait},  32'd1);
    check("rst_ramren", {31'd0, ramREN}, 32'd0);
    check("rst_ramwen", {31'd0, ramWEN}, 32'd0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_iload",   iload,   32'h0);
    check("rst_dload",   dload,   32'h0);
    check("rst_scnt", 32'(dut.scnt_q), 32'd0);
    RST = 1'b0;

    // Icache only, two BUSY cycles before ACCESS.
    step;
    iREN = 1'b1; iaddr = 32'h40; #1;
    check("i_idle_ramren", {31'd0, ramREN}, 32'd0);
    step; ramstate = BUSY; #1;
    check("i_b1_ramren",  {31'd0, ramREN}, 32'd1);
    check("i_b1_ramaddr", ramaddr, 32'h40);
    check("i_b1_iwait",   {31'd0, iwait},  32'd1);
    step; #1;
    check("i_b2_ramaddr", ramaddr, 32'h40);
    step; ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    check("i_acc_ramaddr", ramaddr, 32'h40);
    check("i_acc_iwait",   {31'd0, iwait}, 32'd0);
    check("i_acc_iload",   iload, 32'hDEADBEEF);
    step; iREN = 1'b0; ramstate = FREE; #1;
    check("i_done_iwait",  {31'd0, iwait},  32'd1);
    check("i_done_ramren", {31'd0, ramREN}, 32'd0);

    // Simultaneous icache and dcache read: dcache first, bubble, then icache.
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h80; #1;
    step; ramstate = ACCESS; ramload = 32'hAAAA5555; #1;
    check("s_d_ramaddr", ramaddr, 32'h80);
    check("s_d_dwait",   {31'd0, dwait}, 32'd0);
    check("s_d_dload",   dload, 32'hAAAA5555);
    check("s_d_iwait",   {31'd0, iwait}, 32'd1);
    step; dREN = 1'b0; ramstate = FREE; #1;
    check("s_bub_ramren", {31'd0, ramREN}, 32'd0);
    check("s_bub_dwait",  {31'd0, dwait},  32'd1);
    check("s_bub_scnt", 32'(dut.scnt_q), 32'd1);
    step; ramstate = ACCESS; ramload = 32'h11112222; #1;
    check("s_i_ramaddr", ramaddr, 32'h44);
    check("s_i_iwait",   {31'd0, iwait}, 32'd0);
    check("s_i_iload",   iload, 32'h11112222);
    step; iREN = 1'b0; ramstate = FREE; #1;
    check("s_i_scnt", 32'(dut.scnt_q), 32'd0);

    // Starvation guard: four dcache grants, then icache is forced.
    iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; daddr = 32'h90;
    for (int i = 0; i < 4; i++) begin
      step; ramstate = ACCESS; ramload = 32'(i) + 32'h100; #1;
      check("st_d_ramaddr", ramaddr, 32'h90);
      check("st_d_dwait",   {31'd0, dwait}, 32'd0);
      step; ramstate = FREE; #1;
      check("st_scnt", 32'(dut.scnt_q), 32'(i + 1));
    end
    step; ramstate = ACCESS; ramload = 32'hCAFEF00D; #1;
    check("st_i_ramaddr", ramaddr, 32'h48);
    check("st_i_iwait",   {31'd0, iwait}, 32'd0);
    check("st_i_dwait",   {31'd0, dwait}, 32'd1);
    step; iREN = 1'b0; dREN = 1'b0; ramstate = FREE; #1;
    check("st_scnt_clr", 32'(dut.scnt_q), 32'd0);

    // Write (dREN and dWEN both high) with BUSY, ERROR, then ACCESS.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h12345678;
    step; ramstate = BUSY; #1;
    check("w_busy_ramwen",   {31'd0, ramWEN}, 32'd1);
    check("w_busy_ramren",   {31'd0, ramREN}, 32'd0);
    check("w_busy_ramstore", ramstore, 32'h12345678);
    check("w_busy_ramaddr",  ramaddr, 32'h100);
    step; ramstate = ERROR; #1;
    check("w_err_ramwen",   {31'd0, ramWEN}, 32'd1);
    check("w_err_ramstore", ramstore, 32'h12345678);
    check("w_err_dwait",    {31'd0, dwait}, 32'd1);
    step; ramstate = ACCESS; #1;
    check("w_acc_dwait",  {31'd0, dwait},  32'd0);
    check("w_acc_ramwen", {31'd0, ramWEN}, 32'd1);
    step; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; #1;
    check("w_done_dwait",  {31'd0, dwait},  32'd1);
    check("w_done_ramwen", {31'd0, ramWEN}, 32'd0);

    // Icache drops its request while granted.
    iREN = 1'b1; iaddr = 32'h4C;
    step; ramstate = BUSY; #1;
    check("drop_pre_ramren", {31'd0, ramREN}, 32'd1);
    step; iREN = 1'b0; #1;
    check("drop_ramren", {31'd0, ramREN}, 32'd0);
    check("drop_iwait",  {31'd0, iwait},  32'd1);
    step; ramstate = ACCESS; #1;
    check("drop_idle_iwait",  {31'd0, iwait},  32'd1);
    check("drop_idle_ramren", {31'd0, ramREN}, 32'd0);
    ramstate = FREE;

    // Reset asserted mid-BUSY in DACC.
    iREN = 1'b1; iaddr = 32'h50; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h0BADF00D;
    step; ramstate = BUSY; #1;
    check("r_pre_ramwen", {31'd0, ramWEN}, 32'd1);
    check("r_pre_scnt", 32'(dut.scnt_q), 32'd1);
    RST = 1'b1; #1;
    check("r_ramwen", {31'd0, ramWEN}, 32'd0);
    check("r_ramren", {31'd0, ramREN}, 32'd0);
    check("r_dwait",  {31'd0, dwait},  32'd1);
    check("r_scnt", 32'(dut.scnt_q), 32'd0);
    step; RST = 1'b0; #1;
    check("r_idle_ramwen", {31'd0, ramWEN}, 32'd0);
    step; #1;
    check("r_re_ramwen",  {31'd0, ramWEN}, 32'd1);
    check("r_re_ramaddr", ramaddr, 32'h200);
    check("r_re_scnt", 32'(dut.scnt_q), 32'd1);
    ramstate = ACCESS; #1;
    check("r_re_dwait", {31'd0, dwait}, 32'd0);
    step; iREN = 1'b0; dWEN = 1'b0; ramstate = FREE; #1;
    check("r_end_dwait", {31'd0, dwait}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
